// File: rtl/activity_dispatch_16.sv
// Two-mask activity dispatcher: marks accumulate into accum while the current epoch
// drains work highest-index-first over a valid/ready handshake, with optional idle gap cycles.
module activity_dispatch_16 #(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mark_valid,
   input  logic [3:0]  mark_idx,
   input  logic        start,
   input  logic        clear,
   output logic        out_valid,
   output logic [3:0]  out_idx,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] pending
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DISPATCH = 2'd1;
   localparam logic [1:0] DONE     = 2'd2;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [15:0] accum_q, accum_d;
   logic [15:0] work_q, work_d;
   logic [3:0]  gap_q, gap_d;

   logic [15:0] mark_onehot;
   logic [15:0] snapshot;
   logic [15:0] work_cleared;
   logic [3:0]  hi_idx;
   logic        fire;

   assign mark_onehot = mark_valid ? (16'd1 << mark_idx) : 16'd0;
   assign snapshot    = accum_q | mark_onehot;

   // Priority encoder: last assignment wins, so the highest set bit is selected.
   always_comb begin
      hi_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (work_q[i]) hi_idx = 4'(i);
      end
   end

   assign out_valid    = (state_q == DISPATCH) && (work_q != 16'd0) && (gap_q == 4'd0);
   assign out_idx      = out_valid ? hi_idx : 4'd0;
   assign fire         = out_valid && out_ready;
   assign work_cleared = work_q & ~(16'd1 << hi_idx);

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign pending = accum_q;

   always_comb begin
      state_d = state_q;
      accum_d = accum_q | mark_onehot;
      work_d  = work_q;
      gap_d   = (gap_q != 4'd0) ? (gap_q - 4'd1) : gap_q;
      if (clear) begin
         state_d = IDLE;
         accum_d = 16'd0;
         work_d  = 16'd0;
         gap_d   = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  work_d  = snapshot;
                  accum_d = 16'd0;
                  gap_d   = 4'd0;
                  state_d = (snapshot != 16'd0) ? DISPATCH : DONE;
               end
            end
            DISPATCH: begin
               if (fire) begin
                  work_d = work_cleared;
                  if (work_cleared == 16'd0) begin
                     // No gap after the final index so the next epoch starts without delay.
                     gap_d   = 4'd0;
                     state_d = DONE;
                  end else begin
                     gap_d = GAP_LOAD;
                  end
               end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         accum_q <= 16'd0;
         work_q  <= 16'd0;
         gap_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         accum_q <= accum_d;
         work_q  <= work_d;
         gap_q   <= gap_d;
      end
   end

endmodule
